// File: rtl/vector_compare_seq.sv
// Sequential lane-by-lane vector comparator: one lane per cycle, then a
// one-cycle DONE pulse with the match mask and its summary flags.
module vector_compare_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    localparam int unsigned CW = $clog2(LANES + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   OP,
    input  logic                   ABORT,
    input  logic [WIDTH*LANES-1:0] VEC_A,
    input  logic [WIDTH*LANES-1:0] VEC_B,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [LANES-1:0]       MASK,
    output logic                   ALL_MATCH,
    output logic                   ANY_MATCH,
    output logic [CW-1:0]          MATCH_COUNT
);

    localparam int unsigned IW = $clog2(LANES);
    localparam int unsigned VW = WIDTH * LANES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     a_q, a_d;
    logic [VW-1:0]     b_q, b_d;
    logic              op_q, op_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [LANES-1:0]  wmask_q, wmask_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              all_q, all_d;
    logic              any_q, any_d;
    logic [CW-1:0]     count_q, count_d;

    logic              lane_match_c;
    logic [LANES-1:0]  final_mask_c;
    logic [CW-1:0]     final_count_c;

    // Compare the current lane and fold it into the working mask.
    always_comb begin
        lane_match_c  = (a_q[32'(idx_q) * WIDTH +: WIDTH] ==
                         b_q[32'(idx_q) * WIDTH +: WIDTH]) ^ op_q;
        final_mask_c  = wmask_q;
        final_mask_c[idx_q] = lane_match_c;
        final_count_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            final_count_c = final_count_c + CW'(final_mask_c[i]);
        end
    end

    // Next-state and output-load logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wmask_d = wmask_q;
        mask_d  = mask_q;
        all_d   = all_q;
        any_d   = any_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = VEC_A;
                    b_d     = VEC_B;
                    op_d    = OP;
                    idx_d   = '0;
                    wmask_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    wmask_d = final_mask_c;
                    if (idx_q == IW'(LANES - 1)) begin
                        mask_d  = final_mask_c;
                        all_d   = &final_mask_c;
                        any_d   = |final_mask_c;
                        count_d = final_count_c;
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wmask_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            all_q   <= 1'b0;
            any_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wmask_q <= wmask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            all_q   <= all_d;
            any_q   <= any_d;
            count_q <= count_d;
        end
    end

    // Operand latches need no reset; they are only read in RUN after a capture.
    always_ff @(posedge CLK) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign MASK        = mask_q;
    assign ALL_MATCH   = all_q;
    assign ANY_MATCH   = any_q;
    assign MATCH_COUNT = count_q;

endmodule

// File: tb/tb_vector_compare_seq.sv
// Self-checking bench for vector_compare_seq (WIDTH=32, LANES=4): directed
// scenarios plus randomized operations against a lane-level reference model.
module tb_vector_compare_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned VW    = WIDTH * LANES;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          OP;
    logic          ABORT;
    logic [VW-1:0] VEC_A;
    logic [VW-1:0] VEC_B;
    logic          BUSY;
    logic          DONE;
    logic [3:0]    MASK;
    logic          ALL_MATCH;
    logic          ANY_MATCH;
    logic [CW-1:0] MATCH_COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    // Result the outputs should currently be holding.
    logic [3:0] exp_mask = 4'b0000;

    vector_compare_seq #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .ABORT(ABORT),
        .VEC_A(VEC_A), .VEC_B(VEC_B), .BUSY(BUSY), .DONE(DONE), .MASK(MASK),
        .ALL_MATCH(ALL_MATCH), .ANY_MATCH(ANY_MATCH), .MATCH_COUNT(MATCH_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [VW-1:0] pack4(input int unsigned l0, l1, l2, l3);
        return {l3[31:0], l2[31:0], l1[31:0], l0[31:0]};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: lane i matches when (A[i]==B[i]) differs from OP.
    function automatic logic [3:0] ref_mask(input logic [VW-1:0] a, b, input logic op);
        logic [3:0] m;
        int unsigned ea [4];
        int unsigned eb [4];
        for (int i = 0; i < 4; i++) begin
            ea[i] = a[i*32 +: 32];
            eb[i] = b[i*32 +: 32];
            m[i]  = op ? (ea[i] != eb[i]) : (ea[i] == eb[i]);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_results(input string tag);
        chk({tag, ".mask"},  32'(MASK), 32'(exp_mask));
        chk({tag, ".all"},   32'(ALL_MATCH), 32'(exp_mask == 4'hF));
        chk({tag, ".any"},   32'(ANY_MATCH), 32'(exp_mask != 4'h0));
        chk({tag, ".count"}, 32'(MATCH_COUNT), 32'($countones(exp_mask)));
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One full operation; noise pokes START/operands in RUN and ABORT/START in FIN,
    // hold keeps START high throughout (back-to-back mode).
    task automatic run_op(input string tag, input logic [VW-1:0] a, b, input logic op,
                          input bit noise, input bit hold);
        logic [3:0] m;
        m     = ref_mask(a, b, op);
        VEC_A = a;
        VEC_B = b;
        OP    = op;
        START = 1'b1;
        ABORT = 1'b0;
        step();
        for (int j = 0; j < 4; j++) begin
            chk({tag, ".run_busy"}, 32'(BUSY), 32'd1);
            chk({tag, ".run_done"}, 32'(DONE), 32'd0);
            chk({tag, ".run_mask"}, 32'(MASK), 32'(exp_mask));
            VEC_A = rand_vec();
            VEC_B = rand_vec();
            OP    = 1'($urandom);
            START = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            step();
        end
        exp_mask = m;
        chk({tag, ".fin_done"}, 32'(DONE), 32'd1);
        chk({tag, ".fin_busy"}, 32'(BUSY), 32'd0);
        chk_results({tag, ".fin"});
        ABORT = noise ? 1'($urandom) : 1'b0;
        START = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        step();
        ABORT = 1'b0;
        START = hold;
        chk({tag, ".post_done"}, 32'(DONE), 32'd0);
        chk({tag, ".post_busy"}, 32'(BUSY), 32'd0);
        chk({tag, ".post_mask"}, 32'(MASK), 32'(exp_mask));
    endtask

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        RST   = 1'b1;
        START = 1'b0;
        OP    = 1'b0;
        ABORT = 1'b0;
        VEC_A = '0;
        VEC_B = '0;
        @(negedge CLK);
        step();
        RST = 1'b0;
        chk("reset.busy", 32'(BUSY), 32'd0);
        chk("reset.done", 32'(DONE), 32'd0);
        chk_results("reset");

        // ABORT while idle does nothing.
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("idle_abort.busy", 32'(BUSY), 32'd0);
        chk("idle_abort.done", 32'(DONE), 32'd0);

        // Equal vectors.
        a = pack4(256, 256, 256, 256);
        run_op("equal", a, a, 1'b0, 1'b0, 1'b0);

        // Mixed lanes, both opcodes.
        a = pack4(100, 0, 256, 7);
        b = pack4(4, 0, 256, 8);
        run_op("mixed_eq", a, b, 1'b0, 1'b0, 1'b0);
        chk("mixed_eq.literal", 32'(MASK), 32'h6);
        run_op("mixed_ne", a, b, 1'b1, 1'b0, 1'b0);
        chk("mixed_ne.literal", 32'(MASK), 32'h9);

        // START during RUN with other vectors is ignored.
        run_op("busy_prot", pack4(1, 2, 3, 4), pack4(1, 9, 3, 9), 1'b0, 1'b1, 1'b0);

        // ABORT with idx=2 (two lanes done).
        VEC_A = pack4(5, 5, 5, 5);
        VEC_B = pack4(5, 5, 5, 5);
        OP    = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort.busy", 32'(BUSY), 32'd0);
        chk("abort.done", 32'(DONE), 32'd0);
        chk_results("abort.keep");
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort.no_done", 32'(DONE), 32'd0);
        end
        run_op("after_abort", pack4(9, 8, 7, 6), pack4(9, 0, 7, 0), 1'b0, 1'b0, 1'b0);

        // Reset mid-RUN after an all-match result; START/ABORT asserted alongside.
        a = pack4(256, 256, 256, 256);
        run_op("pre_reset", a, a, 1'b0, 1'b0, 1'b0);
        VEC_A = rand_vec();
        VEC_B = rand_vec();
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        RST   = 1'b1;
        START = 1'b1;
        ABORT = 1'b1;
        step();
        RST   = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        exp_mask = 4'b0000;
        chk("midrst.busy", 32'(BUSY), 32'd0);
        chk("midrst.done", 32'(DONE), 32'd0);
        chk_results("midrst");
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst.no_done", 32'(DONE), 32'd0);
            chk("midrst.idle", 32'(BUSY), 32'd0);
        end

        // Back-to-back with START held high.
        for (int n = 0; n < 4; n++) begin
            a = rand_vec();
            b = a;
            b[n*32 +: 32] = ~a[n*32 +: 32];
            run_op($sformatf("b2b%0d", n), a, b, 1'($urandom), 1'b0, 1'b1);
        end
        START = 1'b0;
        step();

        // Randomized operations, lanes made equal about half the time.
        for (int n = 0; n < 20; n++) begin
            a = rand_vec();
            b = rand_vec();
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(1, 0) == 1) b[l*32 +: 32] = a[l*32 +: 32];
            end
            run_op($sformatf("rand%0d", n), a, b, 1'($urandom), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
